ll8_arb4: RTL and testbench

LL8_ARB4 -- requirements
Module: ll8_arb4

---
 rtl/ll8_arb4_pkg.sv | 10 +
 rtl/rr_pick4.sv | 28 ++
 rtl/ll8_arb4.sv | 141 ++++++++++++++
 tb/tb_ll8_arb4.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ll8_arb4_pkg.sv
// Shared constants for the 4-port LocalLink byte arbiter.
// State encodings and arbitration mode values.
package ll8_arb4_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way candidate picker: round-robin or fixed priority.
// Round-robin searches upward from last+1, wrapping, ending at last.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  input  logic       mode,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] j;

  always_comb begin
    valid = |req;
    idx   = 2'd0;
    j     = 2'd0;
    // Walk from farthest to nearest so the nearest hit wins.
    for (int k = 3; k >= 0; k--) begin
      if (mode) begin
        if (req[k]) idx = 2'(k);
      end else begin
        j = last + 2'(k + 1);
        if (req[j]) idx = j;
      end
    end
  end

endmodule

// File: rtl/ll8_arb4.sv
// 4-port to 1 LocalLink 8-bit packet arbiter with packet lock,
// stall watchdog, sof error flag and packet counter.
module ll8_arb4
  import ll8_arb4_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [3:0]  enable,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_sof,
  input  logic [3:0]  in_eof,
  input  logic [3:0]  in_src_rdy,
  output logic [3:0]  in_dst_rdy,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_src_rdy,
  input  logic        out_dst_rdy,
  output logic [1:0]  grant_o,
  output logic        busy_o,
  output logic [15:0] pkt_count_o,
  output logic        sof_err_o,
  output logic        stall_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] STALL_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [0:0]    state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [15:0]   pkt_q, pkt_d;
  logic          sof_err_q, sof_err_d;
  logic          stall_q, stall_d;
  logic          first_q, first_d;
  logic [CW-1:0] scnt_q, scnt_d;

  logic          active;
  logic          src_g;
  logic          xfer;
  logic          pick_v;
  logic [1:0]    pick_idx;

  rr_pick4 u_pick (
    .req   (in_src_rdy & enable),
    .last  (grant_q),
    .mode  (PRIO_MODE == PRIO_FIXED),
    .valid (pick_v),
    .idx   (pick_idx)
  );

  assign active = (state_q == ST_ACTIVE);
  assign src_g  = in_src_rdy[grant_q];

  // Clear gates the handshake at once so nothing moves in its cycle.
  assign out_src_rdy = active & src_g & ~clear;
  assign in_dst_rdy  = (active && !clear && out_dst_rdy)
                     ? (4'b0001 << grant_q) : 4'b0000;
  assign out_data    = in_data[{grant_q, 3'b000} +: 8];
  assign out_sof     = in_sof[grant_q];
  assign out_eof     = in_eof[grant_q];
  assign xfer        = out_src_rdy & out_dst_rdy;

  assign grant_o     = grant_q;
  assign busy_o      = active;
  assign pkt_count_o = pkt_q;
  assign sof_err_o   = sof_err_q;
  assign stall_o     = stall_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    pkt_d     = pkt_q;
    sof_err_d = sof_err_q;
    stall_d   = 1'b0;
    first_d   = first_q;
    scnt_d    = scnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_v) begin
          state_d = ST_ACTIVE;
          grant_d = pick_idx;
          first_d = 1'b1;
          scnt_d  = '0;
        end
      end
      ST_ACTIVE: begin
        if (xfer) begin
          scnt_d  = '0;
          first_d = 1'b0;
          if (out_sof && !first_q) sof_err_d = 1'b1;
          if (out_eof) begin
            state_d = ST_IDLE;
            pkt_d   = pkt_q + 16'd1;
          end
        end else if (!src_g && TIMEOUT != 0) begin
          if (scnt_q == STALL_LAST) begin
            stall_d = 1'b1;
            scnt_d  = '0;
          end else begin
            scnt_d = scnt_q + CW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'd3;
      pkt_q     <= '0;
      sof_err_q <= 1'b0;
      stall_q   <= 1'b0;
      first_q   <= 1'b0;
      scnt_q    <= '0;
    end else if (clear) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'd3;
      pkt_q     <= '0;
      sof_err_q <= 1'b0;
      stall_q   <= 1'b0;
      first_q   <= 1'b0;
      scnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pkt_q     <= pkt_d;
      sof_err_q <= sof_err_d;
      stall_q   <= stall_d;
      first_q   <= first_d;
      scnt_q    <= scnt_d;
    end
  end

endmodule

// File: tb/tb_ll8_arb4.sv
// Directed bench for ll8_arb4: packet sources per port, transfer log,
// vector table for arbitration order plus multi-cycle sequences.
module tb_ll8_arb4;

  typedef struct packed {
    logic       sof;
    logic       eof;
    logic [7:0] d;
  } beat_t;

  typedef struct {
    int         cyc;
    logic [1:0] g;
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } lent_t;

  typedef struct {
    logic [3:0] en;
    logic [1:0] g;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic [3:0]  enable;
  logic [31:0] in_data;
  logic [3:0]  in_sof, in_eof, in_src_rdy, in_dst_rdy;
  logic [7:0]  out_data;
  logic        out_sof, out_eof, out_src_rdy, out_dst_rdy;
  logic [1:0]  grant_o;
  logic        busy_o, sof_err_o, stall_o;
  logic [15:0] pkt_count_o;

  logic [3:0]  fp_dst;
  logic [7:0]  fp_data;
  logic        fp_sof, fp_eof, fp_src, fp_busy, fp_serr, fp_stall;
  logic [1:0]  fp_grant;
  logic [15:0] fp_pkt;

  beat_t pq[4][$];
  lent_t lg[$];
  lent_t fplg[$];
  logic [3:0] hold, inf;
  int cyc;
  int ncmp = 0;
  int nerr = 0;
  vec_t tv[16];

  always #5 clk = ~clk;

  ll8_arb4 #(.PRIO_MODE(0), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable),
    .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
    .in_src_rdy(in_src_rdy), .in_dst_rdy(in_dst_rdy),
    .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
    .out_src_rdy(out_src_rdy), .out_dst_rdy(out_dst_rdy),
    .grant_o(grant_o), .busy_o(busy_o), .pkt_count_o(pkt_count_o),
    .sof_err_o(sof_err_o), .stall_o(stall_o)
  );

  ll8_arb4 #(.PRIO_MODE(1), .TIMEOUT(16)) dut_fp (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable),
    .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
    .in_src_rdy(in_src_rdy), .in_dst_rdy(fp_dst),
    .out_data(fp_data), .out_sof(fp_sof), .out_eof(fp_eof),
    .out_src_rdy(fp_src), .out_dst_rdy(out_dst_rdy),
    .grant_o(fp_grant), .busy_o(fp_busy), .pkt_count_o(fp_pkt),
    .sof_err_o(fp_serr), .stall_o(fp_stall)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    beat_t b;
    logic r;
    for (int p = 0; p < 4; p++) begin
      if (pq[p].size() > 0) begin
        b = pq[p][0];
        r = !hold[p];
      end else begin
        b = {1'b1, 1'b1, 8'hA0 | 8'(p)};
        r = inf[p] & !hold[p];
      end
      in_data[8*p +: 8] = b.d;
      in_sof[p] = b.sof;
      in_eof[p] = b.eof;
      in_src_rdy[p] = r;
    end
  endtask

  task automatic apply();
    drive();
    #1;
  endtask

  task automatic tick();
    logic [3:0] hs;
    hs = in_src_rdy & in_dst_rdy;
    if (out_src_rdy && out_dst_rdy)
      lg.push_back('{cyc, grant_o, out_data, out_sof, out_eof});
    if (fp_src && out_dst_rdy)
      fplg.push_back('{cyc, fp_grant, fp_data, fp_sof, fp_eof});
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++)
      if (hs[p] && pq[p].size() > 0) void'(pq[p].pop_front());
    cyc++;
    apply();
  endtask

  task automatic wait_log(int n, int budget, string nm);
    int k = 0;
    while (lg.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(nm, 32'(lg.size() >= n ? n : lg.size()), 32'(n));
  endtask

  task automatic push_pkt(int p, int n, logic [7:0] base, int dup);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.sof = (i == 0) || (i == dup);
      b.eof = (i == n - 1);
      b.d = base + 8'(i);
      pq[p].push_back(b);
    end
  endtask

  task automatic flush();
    for (int p = 0; p < 4; p++) pq[p].delete();
    lg.delete();
    fplg.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear = 1'b0;
    enable = 4'h0;
    out_dst_rdy = 1'b1;
    hold = 4'h0;
    inf = 4'h0;
    flush();
    apply();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    apply();
    cyc = 0;
  endtask

  initial begin
    int first, nst, nok;
    logic [3:0] exg[6];
    logic [7:0] exd[6];
    int exc[6];

    tv[0] = '{4'hF, 2'd0};  tv[1] = '{4'hF, 2'd1};
    tv[2] = '{4'hF, 2'd2};  tv[3] = '{4'hF, 2'd3};
    tv[4] = '{4'hF, 2'd0};  tv[5] = '{4'hF, 2'd1};
    tv[6] = '{4'hF, 2'd2};  tv[7] = '{4'hF, 2'd3};
    tv[8] = '{4'h5, 2'd0};  tv[9] = '{4'h5, 2'd2};
    tv[10] = '{4'h8, 2'd3}; tv[11] = '{4'h3, 2'd0};
    tv[12] = '{4'h6, 2'd1}; tv[13] = '{4'h9, 2'd3};
    tv[14] = '{4'h1, 2'd0}; tv[15] = '{4'hE, 2'd1};

    // Reset state
    do_reset();
    chk("rst_grant", 32'(grant_o), 3);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_pkt", 32'(pkt_count_o), 0);
    chk("rst_flags", {sof_err_o, stall_o, out_src_rdy}, 0);
    chk("rst_dst", 32'(in_dst_rdy), 0);
    chk("rst_fp", {fp_busy, fp_serr, fp_stall, fp_src, fp_dst}, 0);

    // Two 3-byte packets on ports 0 and 2
    do_reset();
    enable = 4'hF;
    push_pkt(0, 3, 8'h10, -1);
    push_pkt(2, 3, 8'h20, -1);
    apply();
    wait_log(6, 30, "two_pkt_done");
    exg = '{0, 0, 0, 2, 2, 2};
    exd = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
    exc = '{1, 2, 3, 5, 6, 7};
    for (int i = 0; i < 6; i++)
      chk($sformatf("two_pkt_beat%0d", i),
          {lg[i].g, lg[i].d, 16'(lg[i].cyc)},
          {exg[i][1:0], exd[i], 16'(exc[i])});
    chk("two_pkt_count", 32'(pkt_count_o), 2);

    // Round-robin order under varying enable masks
    do_reset();
    inf = 4'hF;
    for (int i = 0; i < 16; i++) begin
      int n0;
      enable = tv[i].en;
      apply();
      n0 = lg.size();
      wait_log(n0 + 1, 10, $sformatf("rr_done%0d", i));
      chk($sformatf("rr_grant%0d", i), 32'(lg[n0].g), 32'(tv[i].g));
    end

    // Fixed priority: all ready, 8 packets all from port 0
    do_reset();
    inf = 4'hF;
    enable = 4'hF;
    apply();
    for (int k = 0; k < 40 && fplg.size() < 8; k++) tick();
    nok = 0;
    for (int i = 0; i < fplg.size() && i < 8; i++)
      if (fplg[i].g == 2'd0 && fplg[i].d == 8'hA0 &&
          fplg[i].sof && fplg[i].eof) nok++;
    chk("fixed_prio_port0", 32'(nok), 8);

    // Packet lock after enable drops mid-packet
    do_reset();
    push_pkt(1, 4, 8'h40, -1);
    enable = 4'b0010;
    apply();
    wait_log(1, 10, "lock_start");
    enable = 4'b0001;
    push_pkt(0, 2, 8'h50, -1);
    apply();
    wait_log(6, 30, "lock_done");
    exg = '{1, 1, 1, 1, 0, 0};
    exd = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h50, 8'h51};
    for (int i = 0; i < 6; i++)
      chk($sformatf("lock_beat%0d", i), {lg[i].g, lg[i].d},
          {exg[i][1:0], exd[i]});

    // Mid-packet stall on port 3, TIMEOUT=16
    do_reset();
    push_pkt(3, 4, 8'h30, -1);
    enable = 4'b1000;
    apply();
    wait_log(1, 10, "stall_start");
    hold[3] = 1'b1;
    apply();
    first = -1;
    nst = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (stall_o) begin
        if (first < 0) first = i;
        nst++;
      end
    end
    chk("stall_cycle", 32'(first), 16);
    chk("stall_pulses", 32'(nst), 1);
    chk("stall_hold", {busy_o, grant_o}, {1'b1, 2'd3});
    hold[3] = 1'b0;
    apply();
    wait_log(4, 20, "stall_done");
    chk("stall_last", {lg[3].eof, lg[3].d}, {1'b1, 8'h33});
    chk("stall_pkt", 32'(pkt_count_o), 1);

    // Extra sof on byte 2 of a 4-byte packet
    do_reset();
    push_pkt(2, 4, 8'h60, 2);
    enable = 4'b0100;
    apply();
    wait_log(2, 10, "sof_half");
    chk("sof_err_early", 32'(sof_err_o), 0);
    wait_log(4, 10, "sof_done");
    chk("sof_err_set", 32'(sof_err_o), 1);
    chk("sof_fwd", {lg[2].sof, lg[2].d}, {1'b1, 8'h62});
    repeat (3) tick();
    chk("sof_err_sticky", 32'(sof_err_o), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    apply();
    chk("clr_state", {sof_err_o, grant_o, pkt_count_o},
        {1'b0, 2'd3, 16'd0});

    // Async reset on byte 2 of a 5-byte packet
    do_reset();
    push_pkt(1, 5, 8'h70, -1);
    enable = 4'b0010;
    apply();
    wait_log(1, 10, "rst_mid_start");
    chk("rst_mid_pre", 32'(in_dst_rdy), 32'h2);
    reset = 1'b1;
    #1;
    chk("rst_mid_dst", 32'(in_dst_rdy), 0);
    chk("rst_mid_src", 32'(out_src_rdy), 0);
    chk("rst_mid_regs", {busy_o, grant_o, pkt_count_o},
        {1'b0, 2'd3, 16'd0});
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    flush();
    inf = 4'b0011;
    enable = 4'b0011;
    apply();
    wait_log(1, 10, "rst_mid_next");
    chk("rst_mid_grant", 32'(lg[0].g), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
